i2c_eeprom_arbiter: RTL
=======================

# i2c_eeprom_arbiter

Transaction arbiter and sequencer that shares the single byte-level I2C master driving the AT24C64 EEPROM (scl/sda) between two requesters, e.g. the key-driven write path and the display read-back path. It grants requesters round-robin, issues one byte transaction at a time, and enforces the EEPROM internal write cycle (tWR) before accepting further traffic, so a requester's done pulse means the data is committed or valid.

## Interface
- ADDR_W, 13, EEPROM byte address width (8 KB AT24C64)
- DEV_SEL, 3'b000, A2..A0 strap bits; device address = {4'b1010, DEV_SEL}
- TWR_CYCLES, 250000, fixed write-cycle wait in clk cycles (5 ms at 50 MHz)
- POLL_GAP, 5000, idle clk cycles between ACK-poll probes
- POLL_MAX, 64, max ACK-poll probes before error
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request pending, N = 0,1; held until reqN_done
- reqN_we  in  1  1 = byte write, 0 = random byte read
- reqN_addr  in  ADDR_W  byte address
- reqN_wdata  in  8  write data
- reqN_done  out  1  one-cycle completion pulse
- reqN_rdata  out  8  read data, valid from reqN_done until next grant to N
- reqN_err  out  1  NACK/timeout flag, valid with reqN_done
- m_start  out  1  one-cycle pulse launching a master transaction
- m_op  out  2  00 write byte, 01 read byte, 10 address-only probe (START+dev+W+STOP)
- m_dev  out  7  7-bit device address
- m_addr  out  ADDR_W  byte address
- m_wdata  out  8  write byte
- m_done  in  1  one-cycle pulse, transaction finished
- m_nack  in  1  any NACK seen, valid with m_done
- m_rdata  in  8  read byte, valid with m_done

## Operation
- States: IDLE, ISSUE, WAIT_M, TWR, POLL_GAP_S, POLL_ISSUE, POLL_WAIT, RESP.
- IDLE: if any reqN_valid, pick winner, latch we/addr/wdata, go ISSUE. Both valid: grant the one not granted last; last_grant resets to 1 so req0 wins first tie.
- ISSUE: m_start=1 one cycle, m_op/m_addr/m_wdata/m_dev from latch; -> WAIT_M. m_* fields held stable from ISSUE until m_done.
- WAIT_M on m_done: m_nack=1 -> RESP with err=1 (no write wait); read -> capture m_rdata, RESP; write -> TWR (or POLL_GAP_S with macro).
- TWR: count TWR_CYCLES, -> RESP err=0.
- RESP: pulse reqN_done of granted requester, update last_grant, -> IDLE.
- Fields latched at grant; later changes or valid drop ignored, transaction completes and done still pulses.
- Any m_done outside WAIT_M/POLL_WAIT ignored.
- reset_n low mid-operation: all state cleared, in-flight request discarded without done; downstream master shares reset.

## Timing
- Reset values: all reqN_done/reqN_err 0, reqN_rdata 8'h00, m_start 0, m_op 00, m_addr 0, m_wdata 0, m_dev {4'b1010,DEV_SEL}.
- valid seen in IDLE at cycle T -> m_start at T+1.
- m_done at cycle M: read/NACK -> reqN_done at M+1; write -> done at M+1+TWR_CYCLES (fixed mode).
- Back-to-back: next grant earliest one cycle after done; requester may keep valid high for a new request that cycle.
- Timer and poll counters sized $clog2 of parameter; count saturates at terminal value.

## Configuration
- I2C_EEPROM_ACK_POLL_EN defined: after write, POLL_GAP_S waits POLL_GAP cycles, POLL_ISSUE sends probe (m_op=10); m_nack=1 -> retry, m_nack=0 -> RESP err=0; POLL_MAX NACKs -> RESP err=1. TWR state unused.
- Undefined: fixed TWR_CYCLES wait; probe op never issued.

## Structure
- Package i2c_eeprom_pkg: state enum, m_op encodings, EEPROM_DEV_TYPE 4'b1010, default TWR_CYCLES.
- Sub-module i2c_eeprom_rr_arb: 2-way round-robin grant with last_grant register; counters and FSM stay in top.

## Test plan
- req0 write 0x0123<-0xA5, master model acks -> one m_start with m_op 00, req0_done exactly TWR_CYCLES+1 after m_done, err=0.
- req1 read 0x0123 after that write -> m_op 01, req1_rdata=0xA5 one cycle after m_done.
- req0 and req1 valid same cycle from reset -> req0 served first, req1 m_start one cycle after req0_done+1; repeat tie -> alternates.
- Master returns m_nack on write -> done at m_done+1, err=1, no tWR wait.
- With I2C_EEPROM_ACK_POLL_EN, model NACKs 3 probes then ACKs -> 4 probes spaced POLL_GAP, done err=0; always NACK -> err=1 after POLL_MAX probes.
- reset_n low during TWR wait -> no done pulse, outputs at reset values, fresh request after release served normally.

Source files
------------

// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the AT24C64 transaction arbiter.
package i2c_eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_M,
    ST_TWR,
    ST_POLL_GAP_S,
    ST_POLL_ISSUE,
    ST_POLL_WAIT,
    ST_RESP
  } state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_PROBE = 2'b10;

  localparam logic [3:0] EEPROM_DEV_TYPE    = 4'b1010;
  localparam int         DEFAULT_TWR_CYCLES = 250000;

  function automatic logic [6:0] dev_addr(input logic [2:0] sel);
    return {EEPROM_DEV_TYPE, sel};
  endfunction

endpackage

// File: rtl/i2c_eeprom_rr_arb.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module i2c_eeprom_rr_arb (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic upd_en,
  input  logic upd_idx,
  output logic gnt_valid,
  output logic gnt_idx
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d    = last_q;
    gnt_valid = req0 | req1;
    gnt_idx   = (req0 && req1) ? ~last_q : req1;
    if (upd_en) begin
      last_d = upd_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/i2c_eeprom_arbiter.sv
// Shares one byte-level I2C master between two requesters and holds off traffic for tWR.
// Define I2C_EEPROM_ACK_POLL_EN to replace the fixed tWR wait with ACK polling.
module i2c_eeprom_arbiter
  import i2c_eeprom_pkg::*;
#(
  parameter int          ADDR_W     = 13,
  parameter logic [2:0]  DEV_SEL    = 3'b000,
  parameter int          TWR_CYCLES = DEFAULT_TWR_CYCLES,
  parameter int          POLL_GAP   = 5000,
  parameter int          POLL_MAX   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_wdata,
  output logic              req0_done,
  output logic [7:0]        req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_wdata,
  output logic              req1_done,
  output logic [7:0]        req1_rdata,
  output logic              req1_err,
  output logic              m_start,
  output logic [1:0]        m_op,
  output logic [6:0]        m_dev,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata,
  output state_e            dbg_state
);

  localparam int CNT_MAX = (TWR_CYCLES > POLL_GAP) ? TWR_CYCLES : POLL_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PRB_W   = $clog2(POLL_MAX + 1);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRB_W-1:0]  probe_q, probe_d;
  logic [7:0]        rdata0_q, rdata0_d;
  logic [7:0]        rdata1_q, rdata1_d;

  logic arb_valid;
  logic arb_idx;

  i2c_eeprom_rr_arb u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0_valid),
    .req1      (req1_valid),
    .upd_en    (state_q == ST_RESP),
    .upd_idx   (gnt_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    probe_d  = probe_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          op_d    = (arb_idx ? req1_we : req0_we) ? OP_WRITE : OP_READ;
          addr_d  = arb_idx ? req1_addr : req0_addr;
          wdata_d = arb_idx ? req1_wdata : req0_wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          probe_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_M;
      ST_WAIT_M: begin
        if (m_done) begin
          cnt_d = '0;
          if (m_nack) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (op_q == OP_READ) begin
            if (gnt_q) rdata1_d = m_rdata;
            else       rdata0_d = m_rdata;
            state_d = ST_RESP;
          end else begin
`ifdef I2C_EEPROM_ACK_POLL_EN
            state_d = ST_POLL_GAP_S;
`else
            state_d = ST_TWR;
`endif
          end
        end
      end
      // Counter stops at its terminal value; the state change ends the wait.
      ST_TWR: begin
        if (cnt_q == CNT_W'(TWR_CYCLES - 1)) state_d = ST_RESP;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
`ifdef I2C_EEPROM_ACK_POLL_EN
      ST_POLL_GAP_S: begin
        if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
          op_d    = OP_PROBE;
          state_d = ST_POLL_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_POLL_ISSUE: state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (m_done) begin
          cnt_d = '0;
          if (!m_nack) begin
            state_d = ST_RESP;
          end else if (probe_q == PRB_W'(POLL_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            probe_d = probe_q + PRB_W'(1);
            state_d = ST_POLL_GAP_S;
          end
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      op_q     <= OP_WRITE;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      probe_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      probe_q  <= probe_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Master fields come straight from the grant latch, so they hold until m_done.
  assign m_start    = (state_q == ST_ISSUE) || (state_q == ST_POLL_ISSUE);
  assign m_op       = op_q;
  assign m_dev      = dev_addr(DEV_SEL);
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign req0_done  = (state_q == ST_RESP) && !gnt_q;
  assign req1_done  = (state_q == ST_RESP) && gnt_q;
  assign req0_err   = req0_done && err_q;
  assign req1_err   = req1_done && err_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign dbg_state  = state_q;

endmodule
